sht40_meas_sequencer: RTL and testbench
=======================================

// Module: sht40_meas_sequencer
// PURPOSE
//  Sequences SHT40 measurements over the shared I2C master: issues measure command, waits
//  conversion time, issues 6-byte read, collects temp/RH words from the SHT40 CRC/parse block.
//  Retries on NACK/CRC error/timeout; latches last good sample. Sits between top-level
//  control (periodic/trigger) and the I2C master + SHT40 parser.
// PARAMETERS
//  SHT_ADDR       7'h44       SHT40 7-bit I2C address
//  MEAS_CMD       8'hFD       measure command (high precision)
//  CONV_CYCLES    1_000_000   clk cycles between command done and read start (10 ms @100 MHz)
//  PERIOD_CYCLES  100_000_000 cycles between auto measurements (start-to-start)
//  TIMEOUT_CYCLES 2_000_000   max cycles waiting for i2c_done or parser result
//  MAX_RETRY      3           retries per measurement before fault
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   async active-low reset
//  enable         in   1   1 = periodic auto measurement
//  trigger        in   1   1-cycle pulse: one measurement now (ignored unless IDLE)
//  i2c_start      out  1   1-cycle pulse: launch transaction described by i2c_* fields
//  i2c_addr       out  7   slave address (always SHT_ADDR)
//  i2c_rw         out  1   0 = write, 1 = read
//  i2c_wdata      out  8   write byte (MEAS_CMD)
//  i2c_nbytes     out  4   byte count: 1 for write, 6 for read
//  i2c_busy       in   1   master busy
//  i2c_done       in   1   1-cycle pulse: transaction finished
//  i2c_nack       in   1   qualifies i2c_done: slave NACKed
//  temp_ready_in  in   1   parser: temp word CRC-good (level or pulse)
//  rh_ready_in    in   1   parser: RH word CRC-good
//  crc_error_in   in   1   parser: CRC mismatch
//  temp_raw_in    in   16  parser temperature word
//  rh_raw_in      in   16  parser humidity word
//  temperature    out  16  last good raw temperature
//  humidity       out  16  last good raw humidity
//  sample_valid   out  1   1-cycle pulse when temperature/humidity update
//  busy           out  1   1 whenever state != IDLE/PERIOD_WAIT
//  fault          out  1   sticky; set after MAX_RETRY failures, cleared by next success
//  err_count      out  8   total failed attempts, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0 except i2c_addr=SHT_ADDR; state IDLE; counters 0.
//  FSM: IDLE -> (trigger | enable) -> CMD_REQ. CMD_REQ: wait !i2c_busy, pulse i2c_start with
//   rw=0,nbytes=1,wdata=MEAS_CMD -> CMD_WAIT. CMD_WAIT: i2c_done&!nack -> CONV_WAIT; done&nack -> FAIL.
//   CONV_WAIT: count CONV_CYCLES -> RD_REQ. RD_REQ: wait !busy, pulse start rw=1,nbytes=6 -> RD_WAIT.
//   RD_WAIT: latch temp_ok on temp_ready_in, rh_ok on rh_ready_in; crc_error_in or done&nack -> FAIL;
//   i2c_done & temp_ok & rh_ok (or both ok seen after done) -> DONE.
//   DONE: temperature<=temp_raw_in, humidity<=rh_raw_in, sample_valid=1 for 1 cycle, fault<=0,
//   retry<=0 -> PERIOD_WAIT if enable else IDLE.
//   FAIL: err_count+=1 (sat); retry+1; retry < MAX_RETRY -> CMD_REQ, else fault<=1, retry<=0 ->
//   PERIOD_WAIT if enable else IDLE.
//  Timeout counter restarts on entry to CMD_WAIT/RD_WAIT; expiry -> FAIL.
//  PERIOD_WAIT: period counter runs from CMD_REQ entry of previous attempt; at PERIOD_CYCLES -> CMD_REQ;
//   enable low -> IDLE (trigger then accepted).
//  i2c_start is never asserted while i2c_busy=1; exactly one start per CMD_REQ/RD_REQ entry.
//  trigger while busy: dropped, no queueing. temp/humidity never change on a failed attempt.
//  Simultaneous crc_error_in and i2c_done in RD_WAIT: FAIL wins.
//  rst_n low mid-transaction: immediate return to reset values; no start pulse emitted.
//  Latency: trigger -> first i2c_start = 1 cycle when i2c_busy=0.
// STRUCTURE
//  Package sht40_pkg: state enum, SHT_ADDR, MEAS_CMD, byte-count constants (1, 6).
//  One sub-module: sht40_cycle_timer (load/count/expire down-counter) instanced for conversion,
//  timeout and period; FSM stays in top.
// TESTING
//  1. trigger, master acks, parser gives temp 16'h6666 / RH 16'h8000 -> one write(0xFD) start,
//     read start exactly CONV_CYCLES after done, sample_valid pulse, outputs 6666/8000, fault 0.
//  2. NACK on command write twice, then success -> 3 command starts, err_count=2, fault 0, valid pulse.
//  3. crc_error_in on every attempt -> MAX_RETRY+1=4 attempts, fault=1, err_count=4, outputs unchanged.
//  4. i2c_done never arrives -> FAIL at TIMEOUT_CYCLES, retry issued; i2c_busy=1 held -> no start pulse.
//  5. enable=1, PERIOD_CYCLES=1000 (sim) -> starts 1000 cycles apart; trigger mid-cycle ignored.
//  6. rst_n low during CONV_WAIT -> all outputs 0 asynchronously, no read start after release.

Source files
------------

// File: rtl/sht40_pkg.sv
// -----------------------------------------------------------------------------
// sht40_pkg
// Shared constants for the SHT40 measurement sequencer:
//   - FSM state encodings (plain 4-bit constants)
//   - default SHT40 I2C address and measure command
//   - I2C byte counts for the command write and the result read
//   - saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package sht40_pkg;

   localparam logic [3:0] ST_IDLE        = 4'd0;
   localparam logic [3:0] ST_CMD_REQ     = 4'd1;
   localparam logic [3:0] ST_CMD_WAIT    = 4'd2;
   localparam logic [3:0] ST_CONV_WAIT   = 4'd3;
   localparam logic [3:0] ST_RD_REQ      = 4'd4;
   localparam logic [3:0] ST_RD_WAIT     = 4'd5;
   localparam logic [3:0] ST_DONE        = 4'd6;
   localparam logic [3:0] ST_FAIL        = 4'd7;
   localparam logic [3:0] ST_PERIOD_WAIT = 4'd8;

   localparam logic [6:0] SHT_ADDR_DEFAULT = 7'h44;
   localparam logic [7:0] MEAS_CMD_DEFAULT = 8'hFD;

   localparam logic [3:0] NBYTES_WRITE = 4'd1;  // single command byte
   localparam logic [3:0] NBYTES_READ  = 4'd6;  // T msb/lsb/crc + RH msb/lsb/crc

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sht40_cycle_timer.sv
// -----------------------------------------------------------------------------
// sht40_cycle_timer
// Load/count/expire down-counter. Pulsing load with len = N makes expired rise
// in the N-th cycle after the load edge, so a state entered on the load edge
// and left on expired dwells exactly N cycles. Once expired it stays expired
// until the next load.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : restart the count on this edge
//   len        : dwell length in cycles (0 behaves like 1)
//   expired    : count has run out
// -----------------------------------------------------------------------------
module sht40_cycle_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] len,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values of its neighbours; blocking here would create order races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= (len == '0) ? '0 : len - 1'b1;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/sht40_meas_sequencer.sv
// -----------------------------------------------------------------------------
// sht40_meas_sequencer
// Drives the shared I2C master through an SHT40 measurement: write the measure
// command, wait the conversion time, read 6 bytes, and collect the temperature
// and humidity words from the CRC/parse block. Failed attempts (NACK, CRC
// error, timeout) are retried up to MAX_RETRY times before raising fault.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   enable, trigger   : periodic auto-measure enable, one-shot request (IDLE only)
//   i2c_start         : launch pulse for the transaction in i2c_addr/rw/wdata/nbytes
//   i2c_busy/done/nack: master status; nack qualifies done
//   temp_ready_in, rh_ready_in, crc_error_in, temp_raw_in, rh_raw_in : parser
//   temperature, humidity, sample_valid : last good sample and its update pulse
//   busy, fault, err_count              : status
// -----------------------------------------------------------------------------
module sht40_meas_sequencer
   import sht40_pkg::*;
#(
   parameter logic [6:0] SHT_ADDR       = SHT_ADDR_DEFAULT,
   parameter logic [7:0] MEAS_CMD       = MEAS_CMD_DEFAULT,
   parameter int         CONV_CYCLES    = 1_000_000,
   parameter int         PERIOD_CYCLES  = 100_000_000,
   parameter int         TIMEOUT_CYCLES = 2_000_000,
   parameter int         MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        trigger,
   output logic        i2c_start,
   output logic [6:0]  i2c_addr,
   output logic        i2c_rw,
   output logic [7:0]  i2c_wdata,
   output logic [3:0]  i2c_nbytes,
   input  logic        i2c_busy,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   input  logic        temp_ready_in,
   input  logic        rh_ready_in,
   input  logic        crc_error_in,
   input  logic [15:0] temp_raw_in,
   input  logic [15:0] rh_raw_in,
   output logic [15:0] temperature,
   output logic [15:0] humidity,
   output logic        sample_valid,
   output logic        busy,
   output logic        fault,
   output logic [7:0]  err_count
);

   localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

   logic [3:0] state;
   logic [3:0] next_state;
   logic [7:0] retry;
   logic       temp_ok;
   logic       rh_ok;
   logic       done_seen;

   logic       conv_expired;
   logic       tmo_expired;
   logic       period_expired;
   logic       enter_cmd;
   logic       enter_meas;
   logic       enter_conv;
   logic       enter_rd;
   logic       enter_wait;
   logic       rd_fail;
   logic       rd_complete;

   assign i2c_addr  = SHT_ADDR;
   assign busy      = (state != ST_IDLE) && (state != ST_PERIOD_WAIT);
   // Combinational so the master can never see start while it reports busy.
   assign i2c_start = ((state == ST_CMD_REQ) || (state == ST_RD_REQ)) && !i2c_busy;

   assign rd_fail     = crc_error_in || (i2c_done && i2c_nack);
   // Done and both CRC-good words may arrive in any order or together.
   assign rd_complete = (done_seen || (i2c_done && !i2c_nack)) &&
                        (temp_ok || temp_ready_in) && (rh_ok || rh_ready_in);

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:        if (trigger || enable) next_state = ST_CMD_REQ;
         ST_CMD_REQ:     if (!i2c_busy) next_state = ST_CMD_WAIT;
         ST_CMD_WAIT: begin
            if (i2c_done)         next_state = i2c_nack ? ST_FAIL : ST_CONV_WAIT;
            else if (tmo_expired) next_state = ST_FAIL;
         end
         ST_CONV_WAIT:   if (conv_expired) next_state = ST_RD_REQ;
         ST_RD_REQ:      if (!i2c_busy) next_state = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (rd_fail)          next_state = ST_FAIL;
            else if (rd_complete) next_state = ST_DONE;
            else if (tmo_expired) next_state = ST_FAIL;
         end
         ST_DONE:        next_state = enable ? ST_PERIOD_WAIT : ST_IDLE;
         ST_FAIL: begin
            if (retry < RETRY_LIMIT) next_state = ST_CMD_REQ;
            else                     next_state = enable ? ST_PERIOD_WAIT : ST_IDLE;
         end
         ST_PERIOD_WAIT: begin
            if (!enable)             next_state = ST_IDLE;
            else if (period_expired) next_state = ST_CMD_REQ;
         end
         default:        next_state = ST_IDLE;
      endcase
   end

   assign enter_cmd  = (next_state == ST_CMD_REQ)   && (state != ST_CMD_REQ);
   assign enter_rd   = (next_state == ST_RD_REQ)    && (state != ST_RD_REQ);
   assign enter_conv = (next_state == ST_CONV_WAIT) && (state != ST_CONV_WAIT);
   assign enter_wait = ((next_state == ST_CMD_WAIT) && (state != ST_CMD_WAIT)) ||
                       ((next_state == ST_RD_WAIT)  && (state != ST_RD_WAIT));
   // Period runs start-to-start between measurements; retries do not restart it.
   assign enter_meas = enter_cmd && ((state == ST_IDLE) || (state == ST_PERIOD_WAIT));

   // Conversion dwell is one short of CONV_CYCLES so the read start lands
   // exactly CONV_CYCLES cycles after the command's done pulse.
   sht40_cycle_timer #(.WIDTH(32)) u_conv_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (enter_conv),
      .len     (32'(CONV_CYCLES - 1)),
      .expired (conv_expired)
   );

   sht40_cycle_timer #(.WIDTH(32)) u_tmo_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (enter_wait),
      .len     (32'(TIMEOUT_CYCLES)),
      .expired (tmo_expired)
   );

   sht40_cycle_timer #(.WIDTH(32)) u_period_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (enter_meas),
      .len     (32'(PERIOD_CYCLES)),
      .expired (period_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         retry        <= '0;
         temp_ok      <= 1'b0;
         rh_ok        <= 1'b0;
         done_seen    <= 1'b0;
         i2c_rw       <= 1'b0;
         i2c_wdata    <= '0;
         i2c_nbytes   <= '0;
         temperature  <= '0;
         humidity     <= '0;
         sample_valid <= 1'b0;
         fault        <= 1'b0;
         err_count    <= '0;
      end else begin
         state        <= next_state;
         sample_valid <= 1'b0;

         if (enter_cmd) begin
            i2c_rw     <= 1'b0;
            i2c_wdata  <= MEAS_CMD;
            i2c_nbytes <= NBYTES_WRITE;
         end
         if (enter_rd) begin
            i2c_rw     <= 1'b1;
            i2c_nbytes <= NBYTES_READ;
            temp_ok    <= 1'b0;
            rh_ok      <= 1'b0;
            done_seen  <= 1'b0;
         end

         if (state == ST_RD_WAIT) begin
            if (temp_ready_in)          temp_ok   <= 1'b1;
            if (rh_ready_in)            rh_ok     <= 1'b1;
            if (i2c_done && !i2c_nack)  done_seen <= 1'b1;
         end

         if (state == ST_DONE) begin
            temperature  <= temp_raw_in;
            humidity     <= rh_raw_in;
            sample_valid <= 1'b1;
            fault        <= 1'b0;
            retry        <= '0;
         end

         if (state == ST_FAIL) begin
            err_count <= sat_inc8(err_count);
            if (retry < RETRY_LIMIT) begin
               retry <= retry + 8'd1;
            end else begin
               retry <= '0;
               fault <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sht40_meas_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sht40_meas_sequencer
// Directed bench: acts as I2C master and SHT40 parser, walking the sequencer
// through a clean measurement, command NACKs, persistent CRC errors, a
// timeout with the master held busy, periodic operation and a mid-flight reset.
// -----------------------------------------------------------------------------
module tb_sht40_meas_sequencer;

   localparam int CONV = 20;
   localparam int PER  = 1000;
   localparam int TMO  = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        i2c_start;
   logic [6:0]  i2c_addr;
   logic        i2c_rw;
   logic [7:0]  i2c_wdata;
   logic [3:0]  i2c_nbytes;
   logic        i2c_busy = 1'b0;
   logic        i2c_done = 1'b0;
   logic        i2c_nack = 1'b0;
   logic        temp_ready_in = 1'b0;
   logic        rh_ready_in = 1'b0;
   logic        crc_error_in = 1'b0;
   logic [15:0] temp_raw_in = '0;
   logic [15:0] rh_raw_in = '0;
   logic [15:0] temperature;
   logic [15:0] humidity;
   logic        sample_valid;
   logic        busy;
   logic        fault;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int starts = 0;
   int wr_starts = 0;
   int valids = 0;
   int busy_viol = 0;

   sht40_meas_sequencer #(
      .CONV_CYCLES    (CONV),
      .PERIOD_CYCLES  (PER),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .trigger       (trigger),
      .i2c_start     (i2c_start),
      .i2c_addr      (i2c_addr),
      .i2c_rw        (i2c_rw),
      .i2c_wdata     (i2c_wdata),
      .i2c_nbytes    (i2c_nbytes),
      .i2c_busy      (i2c_busy),
      .i2c_done      (i2c_done),
      .i2c_nack      (i2c_nack),
      .temp_ready_in (temp_ready_in),
      .rh_ready_in   (rh_ready_in),
      .crc_error_in  (crc_error_in),
      .temp_raw_in   (temp_raw_in),
      .rh_raw_in     (rh_raw_in),
      .temperature   (temperature),
      .humidity      (humidity),
      .sample_valid  (sample_valid),
      .busy          (busy),
      .fault         (fault),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   // Cycle index and what the master sees on each edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (i2c_start) begin
         starts <= starts + 1;
         if (!i2c_rw)  wr_starts <= wr_starts + 1;
         if (i2c_busy) busy_viol <= busy_viol + 1;
      end
      if (sample_valid) valids <= valids + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string tag, input int limit);
      int n = 0;
      while (!i2c_start && n < limit) begin
         tick();
         n++;
      end
      check(tag, i2c_start, 1'b1);
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n = 0;
      while (!sample_valid && n < limit) begin
         tick();
         n++;
      end
      check(tag, sample_valid, 1'b1);
   endtask

   // Entered with a command-write start visible; finishes with a good sample.
   task automatic run_good(input string tag, input logic [15:0] t, input logic [15:0] h,
                           input bit late_ready);
      int d;
      check({tag, "_wr_rw"}, i2c_rw, 1'b0);
      check({tag, "_wr_nbytes"}, i2c_nbytes, 4'd1);
      check({tag, "_wr_data"}, i2c_wdata, 8'hFD);
      tick();
      i2c_done = 1'b1;
      d = cyc;
      tick();
      i2c_done = 1'b0;
      wait_start({tag, "_rd_start"}, CONV + 5);
      check({tag, "_conv_gap"}, cyc - d, CONV);
      check({tag, "_rd_rw"}, i2c_rw, 1'b1);
      check({tag, "_rd_nbytes"}, i2c_nbytes, 4'd6);
      tick();
      temp_raw_in = t;
      rh_raw_in   = h;
      if (!late_ready) begin
         temp_ready_in = 1'b1;
         rh_ready_in   = 1'b1;
         i2c_done      = 1'b1;
         tick();
         i2c_done = 1'b0;
      end else begin
         i2c_done = 1'b1;
         tick();
         i2c_done = 1'b0;
         tick();
         temp_ready_in = 1'b1;
         tick();
         temp_ready_in = 1'b0;
         rh_ready_in   = 1'b1;
         tick();
         rh_ready_in = 1'b0;
      end
      wait_valid({tag, "_valid"}, 10);
      check({tag, "_temp"}, temperature, t);
      check({tag, "_hum"}, humidity, h);
      check({tag, "_fault"}, fault, 1'b0);
      tick();
      temp_ready_in = 1'b0;
      rh_ready_in   = 1'b0;
      check({tag, "_valid_1cyc"}, sample_valid, 1'b0);
   endtask

   initial begin
      int s;
      int p0;
      int n0;
      int w0;
      int v0;

      // Reset state
      #12;
      check("rst_temp", temperature, 16'h0);
      check("rst_hum", humidity, 16'h0);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_fault", fault, 1'b0);
      check("rst_err", err_count, 8'h0);
      check("rst_start", i2c_start, 1'b0);
      check("rst_addr", i2c_addr, 7'h44);
      check("rst_nbytes", i2c_nbytes, 4'h0);
      check("rst_wdata", i2c_wdata, 8'h0);
      rst_n = 1'b1;
      tick();
      tick();

      // 1: clean triggered measurement, start one cycle after trigger
      w0 = wr_starts;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t1_latency", i2c_start, 1'b1);
      check("t1_busy", busy, 1'b1);
      run_good("t1", 16'h6666, 16'h8000, 1'b0);
      check("t1_idle", busy, 1'b0);
      check("t1_wr_count", wr_starts - w0, 1);
      check("t1_err", err_count, 8'd0);

      // 2: two command NACKs, then success with late parser results
      w0 = wr_starts;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_start("t2_nack_start", 5);
         tick();
         i2c_done = 1'b1;
         i2c_nack = 1'b1;
         tick();
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
      end
      wait_start("t2_final_start", 5);
      run_good("t2", 16'h1234, 16'h5678, 1'b1);
      check("t2_wr_count", wr_starts - w0, 3);
      check("t2_err", err_count, 8'd2);

      // 3: CRC error on every attempt -> 4 attempts then fault
      n0 = starts;
      v0 = valids;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_start("t3_wr_start", 5);
         if (i == 3) begin
            check("t3_fault_before_last", fault, 1'b0);
            check("t3_err_before_last", err_count, 8'd5);
         end
         tick();
         i2c_done = 1'b1;
         tick();
         i2c_done = 1'b0;
         wait_start("t3_rd_start", CONV + 5);
         tick();
         crc_error_in = 1'b1;
         i2c_done     = (i == 1);  // done and CRC error together: failure wins
         temp_ready_in = (i == 1);
         rh_ready_in   = (i == 1);
         tick();
         crc_error_in  = 1'b0;
         i2c_done      = 1'b0;
         temp_ready_in = 1'b0;
         rh_ready_in   = 1'b0;
      end
      repeat (4) tick();
      check("t3_fault", fault, 1'b1);
      check("t3_err", err_count, 8'd6);
      check("t3_busy", busy, 1'b0);
      check("t3_starts", starts - n0, 8);
      check("t3_temp_kept", temperature, 16'h1234);
      check("t3_hum_kept", humidity, 16'h5678);
      check("t3_no_valid", valids - v0, 0);

      // 4: done never arrives -> timeout; retry held off while master busy
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      wait_start("t4_start", 3);
      s = cyc;
      tick();
      i2c_busy = 1'b1;
      while (cyc < s + TMO + 1) tick();
      check("t4_err_before_tmo", err_count, 8'd6);
      check("t4_busy_in_wait", busy, 1'b1);
      tick();
      check("t4_err_after_tmo", err_count, 8'd7);
      check("t4_fault_held", fault, 1'b1);
      n0 = starts;
      repeat (5) begin
         check("t4_no_start_busy", i2c_start, 1'b0);
         tick();
      end
      check("t4_start_count_busy", starts - n0, 0);
      i2c_busy = 1'b0;
      #1;
      check("t4_retry_start", i2c_start, 1'b1);
      run_good("t4", 16'h0ABC, 16'h0DEF, 1'b0);
      check("t4_err_final", err_count, 8'd7);

      // 5: periodic mode, starts PER cycles apart, trigger ignored in between
      enable = 1'b1;
      tick();
      wait_start("t5_first", 3);
      p0 = cyc;
      run_good("t5a", 16'h1111, 16'h2222, 1'b0);
      check("t5_period_idle", busy, 1'b0);
      repeat (100) tick();
      n0 = starts;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t5_trig_ignored_busy", busy, 1'b0);
      check("t5_trig_ignored_start", i2c_start, 1'b0);
      wait_start("t5_second", PER + 10);
      check("t5_period_gap", cyc - p0, PER);
      check("t5_no_extra_start", starts - n0, 0);
      run_good("t5b", 16'h3333, 16'h4444, 1'b0);
      enable = 1'b0;
      tick();
      n0 = starts;
      repeat (PER + 10) tick();
      check("t5_disabled_starts", starts - n0, 0);
      check("t5_disabled_busy", busy, 1'b0);

      // 6: reset during conversion wait
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      wait_start("t6_start", 3);
      tick();
      i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
      repeat (3) tick();
      check("t6_busy_pre", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_busy", busy, 1'b0);
      check("t6_async_temp", temperature, 16'h0);
      check("t6_async_hum", humidity, 16'h0);
      check("t6_async_err", err_count, 8'h0);
      check("t6_async_nbytes", i2c_nbytes, 4'h0);
      check("t6_async_addr", i2c_addr, 7'h44);
      n0 = starts;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (CONV + 10) tick();
      check("t6_no_read_start", starts - n0, 0);
      check("t6_idle", busy, 1'b0);

      check("start_while_busy", busy_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
